// File: rtl/adder_error_monitor_if.sv
// ----------------------------------------------------------------------------
// adder_error_monitor_if
// Purpose : bundles the control, sample handshake and result signals exchanged
//           between the evaluation harness (master) and adder_error_monitor
//           (slave).
// Signals : start, num_samples          - window control from the harness
//           in_valid, in_ready          - sample handshake
//           approx_res, exact_res       - {cout,sum} pair from the two adders
//           busy, done                  - window status
//           sample_count, err_count,
//           sum_ed, max_ed              - accumulated window results
// ----------------------------------------------------------------------------
interface adder_error_monitor_if #(
    parameter int N     = 4,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
);
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [N:0]       approx_res;
    logic [N:0]       exact_res;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] sum_ed;
    logic [N:0]       max_ed;

    modport master (
        output start, num_samples, in_valid, approx_res, exact_res,
        input  in_ready, busy, done, sample_count, err_count, sum_ed, max_ed
    );

    modport slave (
        input  start, num_samples, in_valid, approx_res, exact_res,
        output in_ready, busy, done, sample_count, err_count, sum_ed, max_ed
    );
endinterface

// File: rtl/adder_error_monitor.sv
// ----------------------------------------------------------------------------
// adder_error_monitor
// Purpose : characterises an approximate adder against the exact ripple-carry
//           adder over a programmed window of samples. Each accepted sample
//           pair yields an error distance ED = |approx - exact| (N+1 bits, no
//           wrap) and a not-equal flag; the window accumulates the error
//           count, a saturating ED sum and the maximum ED.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           io_mon - adder_error_monitor_if.slave (control, sample handshake,
//                    status and result outputs)
// ----------------------------------------------------------------------------
module adder_error_monitor #(
    parameter int N     = 4,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_error_monitor_if.slave  io_mon
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_window;
    logic [CNT_W-1:0] r_sample_count;
    logic [CNT_W-1:0] r_err_count;
    logic [ACC_W-1:0] r_sum_ed;
    logic [N:0]       r_max_ed;
    logic             r_pipe_valid;
    logic [N:0]       r_pipe_ed;
    logic             r_pipe_ne;
    logic             r_busy;
    logic             r_done;
    logic             r_in_ready;

    logic [N:0]       w_ed;
    logic             w_ne;
    logic             w_handshake;
    logic [ACC_W:0]   w_sum_wide;
    logic [ACC_W-1:0] w_sum_sat;
    logic [N:0]       w_max_next;
    logic [CNT_W-1:0] w_err_next;
    logic [CNT_W-1:0] w_count_next;

    // ED is taken as the magnitude of the difference so that it never wraps
    // modulo 2^(N+1). The sum is formed one bit wider so the carry out tells
    // us when to clamp at all-ones instead of rolling over.
    always_comb begin
        w_ed         = (io_mon.approx_res >= io_mon.exact_res)
                     ? (io_mon.approx_res - io_mon.exact_res)
                     : (io_mon.exact_res - io_mon.approx_res);
        w_ne         = (io_mon.approx_res != io_mon.exact_res);
        w_handshake  = io_mon.in_valid && r_in_ready;
        w_sum_wide   = {1'b0, r_sum_ed} + (ACC_W+1)'(r_pipe_ed);
        w_sum_sat    = w_sum_wide[ACC_W] ? '1 : w_sum_wide[ACC_W-1:0];
        w_max_next   = (r_pipe_ed > r_max_ed) ? r_pipe_ed : r_max_ed;
        w_err_next   = r_err_count + CNT_W'(r_pipe_ne);
        w_count_next = r_sample_count + CNT_W'(1);
    end

    // Window FSM. in_ready, busy and done are all registered so the harness
    // never sees a combinational path from in_valid to in_ready. A handshake
    // loads the one-entry pipeline; the entry is folded into the accumulators
    // on the following edge, which is why DRAIN exists after the last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_window       <= '0;
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_sum_ed       <= '0;
            r_max_ed       <= '0;
            r_pipe_valid   <= 1'b0;
            r_pipe_ed      <= '0;
            r_pipe_ne      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_in_ready     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (io_mon.start) begin
                        r_sample_count <= '0;
                        r_err_count    <= '0;
                        r_sum_ed       <= '0;
                        r_max_ed       <= '0;
                        r_pipe_valid   <= 1'b0;
                        if (io_mon.num_samples != '0) begin
                            r_window   <= io_mon.num_samples;
                            r_busy     <= 1'b1;
                            r_in_ready <= 1'b1;
                            r_state    <= S_RUN;
                        end else begin
                            // Empty window: results are already final.
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_RUN: begin
                    if (r_pipe_valid) begin
                        r_err_count <= w_err_next;
                        r_sum_ed    <= w_sum_sat;
                        r_max_ed    <= w_max_next;
                    end
                    if (w_handshake) begin
                        r_pipe_ed      <= w_ed;
                        r_pipe_ne      <= w_ne;
                        r_pipe_valid   <= 1'b1;
                        r_sample_count <= w_count_next;
                        if (w_count_next == r_window) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end else begin
                        r_pipe_valid <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    if (r_pipe_valid) begin
                        r_err_count <= w_err_next;
                        r_sum_ed    <= w_sum_sat;
                        r_max_ed    <= w_max_next;
                    end
                    r_pipe_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                    r_state      <= S_DONE;
                end

                S_DONE: begin
                    // A start arriving here is deliberately dropped.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_mon.in_ready     = r_in_ready;
    assign io_mon.busy         = r_busy;
    assign io_mon.done         = r_done;
    assign io_mon.sample_count = r_sample_count;
    assign io_mon.err_count    = r_err_count;
    assign io_mon.sum_ed       = r_sum_ed;
    assign io_mon.max_ed       = r_max_ed;

endmodule

// File: doc/adder_error_monitor.md
Name: adder_error_monitor

Overview:
- Sequential characterisation stage that sits directly downstream of the N-bit ripple-carry adder and its approximate variants.
- Each sample is a pair of (N+1)-bit results: {cout,sum} from the approximate adder and {cout,sum} from the exact adder.
- Over a programmed window of samples, the block accumulates error count, sum of error distances (ED) and maximum ED.
- Used by the evaluation harness to compute error rate and mean ED per adder configuration.

Parameters:
N, 4, adder operand width; each sample input is N+1 bits (sum plus carry-out)
CNT_W, 16, width of the sample-window and count registers
ACC_W, 32, width of the ED accumulator; must be >= N+1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a measurement window; honoured in IDLE only
num_samples  input  CNT_W  window length; sampled on the accepted start
in_valid  input  1  sample pair present this cycle
in_ready  output  1  block accepts a sample this cycle
approx_res  input  N+1  {cout,sum} from the approximate adder
exact_res  input  N+1  {cout,sum} from the exact ripple-carry adder
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse; results are final
sample_count  output  CNT_W  samples accepted in the current or last window
err_count  output  CNT_W  samples with approx_res != exact_res
sum_ed  output  ACC_W  saturating sum of |approx_res - exact_res|
max_ed  output  N+1  largest ED seen in the window

Behaviour:
- Reset: asynchronous on rst_n low; all outputs and registers return to 0; state becomes IDLE.
  - Assertion mid-window abandons the window with no done pulse.
- States:
  - IDLE: busy=0, in_ready=0.
    - start with num_samples!=0: clear all result registers, latch window length, go to RUN.
    - start with num_samples==0: clear results, go to DONE.
  - RUN: in_ready = (sample_count < latched window); in_ready is derived from registers only, with no combinational path from in_valid.
    - Handshake occurs when in_valid && in_ready at a clock edge.
    - On each handshake, the pipeline register captures ED = |approx_res - exact_res|, computed unsigned at N+1 bits with no modular wrap, plus ne = (approx_res != exact_res); sample_count increments.
    - When the final handshake occurs, go to DRAIN.
  - DRAIN: one cycle.
    - The last pipeline entry is accumulated.
    - in_ready=0, busy=1.
    - Go to DONE.
  - DONE: done=1 for exactly one cycle; busy=0; go to IDLE.
- Accumulation: one cycle after each handshake:
  - err_count += ne
  - sum_ed += ED, saturating at 2^ACC_W-1 and never wrapping
  - max_ed = max(max_ed, ED)
- Latency:
  - Final handshake at edge k: accumulators are final after edge k+1; done is high in the cycle following edge k+1.
  - Empty window: done is high in the cycle following the start edge.
- Result outputs hold their values after done until the next accepted start clears them.
- Ignored inputs:
  - start while busy or in DONE.
  - in_valid while in_ready=0.
  - Input data when no handshake occurs.
- Input gaps: in_valid low cycles in RUN stall accumulation only; no timeout.
- num_samples changes after the start edge have no effect on the running window.
- A start pulse in the same cycle as done (state DONE) is ignored; software must wait for IDLE.

Test Plan:
- Basic window:
  - Stimulus: N=4, start with num_samples=3; continuous valid pairs (approx,exact) = (5,5), (7,9), (20,16).
  - Required: sample_count=3, err_count=2, sum_ed=6, max_ed=4.
  - Required: done is a single-cycle pulse, high in the cycle after the edge following the 3rd handshake.
  - Required: in_ready is low after the 3rd handshake.
- Backpressure/gaps:
  - Stimulus: same window with in_valid toggling 1,0,0,1,0,1, then in_valid held high.
  - Required: exactly 3 handshakes are counted; samples offered after the 3rd are ignored; results match the basic window.
- Empty window:
  - Stimulus: start with num_samples=0.
  - Required: done is high in the cycle after the start edge; all results are 0; in_ready is never asserted.
- No wrap / saturation:
  - Stimulus: ACC_W=8; approx=0, exact=31 gives ED=31; run 10 such samples.
  - Required: sum_ed=255 (saturated), err_count=10, max_ed=31.
- Reset and illegal start:
  - Stimulus: assert rst_n low mid-RUN after 2 handshakes.
  - Required: all outputs are 0 immediately, state is IDLE, no done pulse.
  - Stimulus: in a new window, pulse start while busy.
  - Required: the start is ignored; counts continue unaffected.
- Result hold:
  - Stimulus: after done, drive random in_valid/data for 20 cycles.
  - Required: all results are unchanged until the next start, which clears them to 0.
